// File: rtl/imuldiv_muldiv_dispatch_pkg.sv
// Shared mul/div request definitions: function codes, legality, divider signedness.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: muldiv_fn_e codes, illegal-fn floor, divider sign encoding,
//           muldivreq_msg_t held-request struct, result_sel_e, decode helpers.
package imuldiv_muldiv_dispatch_pkg;

    typedef enum logic [2:0] {
        FN_MUL  = 3'd0,
        FN_DIV  = 3'd1,
        FN_DIVU = 3'd2,
        FN_REM  = 3'd3,
        FN_REMU = 3'd4
    } muldiv_fn_e;

    // Codes at or above this value are not operations.
    localparam logic [2:0] FN_ILLEGAL_MIN = 3'd5;

    // Encoding of the divider's one-bit fn field.
    localparam logic DIV_FN_SIGNED   = 1'b1;
    localparam logic DIV_FN_UNSIGNED = 1'b0;

    typedef struct packed {
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
    } muldivreq_msg_t;

    // Which slice of which unit response lands in the result register.
    typedef enum logic [1:0] {
        RSEL_ZERO    = 2'd0,
        RSEL_MUL_LO  = 2'd1,
        RSEL_DIV_QUO = 2'd2,
        RSEL_DIV_REM = 2'd3
    } result_sel_e;

    function automatic logic fn_is_illegal(input logic [2:0] fn);
        return fn >= FN_ILLEGAL_MIN;
    endfunction

    function automatic logic fn_is_rem(input logic [2:0] fn);
        return (fn == FN_REM) || (fn == FN_REMU);
    endfunction

    function automatic logic fn_div_sign(input logic [2:0] fn);
        return ((fn == FN_DIV) || (fn == FN_REM)) ? DIV_FN_SIGNED : DIV_FN_UNSIGNED;
    endfunction

endpackage

// File: rtl/imuldiv_muldiv_dispatch_ctrl.sv
// Dispatch control: one-op-at-a-time FSM steering requests to the multiplier or divider.
// Latency: accept -> ISSUE next cycle; unit response -> RESP next cycle; illegal fn -> RESP next cycle.
// Backpressure: every val/rdy output is a registered decode of state; stalls simply hold the state.
// Ports: clk/reset; muldivreq_val + raw fn for dispatch, fn_reg for result select;
//        unit and response handshakes; req_en/result_en/result_sel steer the datapath.
module imuldiv_muldiv_dispatch_ctrl
    import imuldiv_muldiv_dispatch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        muldivreq_val,
    input  logic [2:0]  req_fn,
    input  logic [2:0]  fn_reg,
    output logic        muldivreq_rdy,

    output logic        muldivresp_val,
    input  logic        muldivresp_rdy,

    output logic        mulreq_val,
    input  logic        mulreq_rdy,
    input  logic        mulresp_val,
    output logic        mulresp_rdy,

    output logic        divreq_val,
    input  logic        divreq_rdy,
    input  logic        divresp_val,
    output logic        divresp_rdy,

    output logic        req_en,
    output logic        result_en,
    output result_sel_e result_sel
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE_MUL = 3'd1,
        S_WAIT_MUL  = 3'd2,
        S_ISSUE_DIV = 3'd3,
        S_WAIT_DIV  = 3'd4,
        S_RESP      = 3'd5
    } state_e;

    state_e state_q, state_d;

    // Handshake outputs are flopped from the next-state decode so they are
    // glitch-free and exactly track state_q.
    logic muldivreq_rdy_q,  muldivreq_rdy_d;
    logic muldivresp_val_q, muldivresp_val_d;
    logic mulreq_val_q,     mulreq_val_d;
    logic mulresp_rdy_q,    mulresp_rdy_d;
    logic divreq_val_q,     divreq_val_d;
    logic divresp_rdy_q,    divresp_rdy_d;

    always_comb begin
        state_d    = state_q;
        req_en     = 1'b0;
        result_en  = 1'b0;
        result_sel = RSEL_ZERO;

        case (state_q)
            S_IDLE: begin
                if (muldivreq_val) begin
                    req_en = 1'b1;
                    if (fn_is_illegal(req_fn)) begin
                        // No unit involved: answer zero straight away.
                        result_en  = 1'b1;
                        result_sel = RSEL_ZERO;
                        state_d    = S_RESP;
                    end else if (req_fn == FN_MUL) begin
                        state_d = S_ISSUE_MUL;
                    end else begin
                        state_d = S_ISSUE_DIV;
                    end
                end
            end
            S_ISSUE_MUL: if (mulreq_rdy) state_d = S_WAIT_MUL;
            S_WAIT_MUL: begin
                result_sel = RSEL_MUL_LO;
                if (mulresp_val) begin
                    result_en = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_ISSUE_DIV: if (divreq_rdy) state_d = S_WAIT_DIV;
            S_WAIT_DIV: begin
                result_sel = fn_is_rem(fn_reg) ? RSEL_DIV_REM : RSEL_DIV_QUO;
                if (divresp_val) begin
                    result_en = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: if (muldivresp_rdy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (reset) begin
            req_en    = 1'b0;
            result_en = 1'b0;
        end

        muldivreq_rdy_d  = (state_d == S_IDLE);
        muldivresp_val_d = (state_d == S_RESP);
        mulreq_val_d     = (state_d == S_ISSUE_MUL);
        mulresp_rdy_d    = (state_d == S_WAIT_MUL);
        divreq_val_d     = (state_d == S_ISSUE_DIV);
        divresp_rdy_d    = (state_d == S_WAIT_DIV);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            muldivreq_rdy_q  <= 1'b1;
            muldivresp_val_q <= 1'b0;
            mulreq_val_q     <= 1'b0;
            mulresp_rdy_q    <= 1'b0;
            divreq_val_q     <= 1'b0;
            divresp_rdy_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            muldivreq_rdy_q  <= muldivreq_rdy_d;
            muldivresp_val_q <= muldivresp_val_d;
            mulreq_val_q     <= mulreq_val_d;
            mulresp_rdy_q    <= mulresp_rdy_d;
            divreq_val_q     <= divreq_val_d;
            divresp_rdy_q    <= divresp_rdy_d;
        end
    end

    // Reset is synchronous, so the flops still hold pre-reset values during the
    // reset cycle itself; mask them so no handshake is offered while reset is high.
    assign muldivreq_rdy  = muldivreq_rdy_q  & ~reset;
    assign muldivresp_val = muldivresp_val_q & ~reset;
    assign mulreq_val     = mulreq_val_q     & ~reset;
    assign mulresp_rdy    = mulresp_rdy_q    & ~reset;
    assign divreq_val     = divreq_val_q     & ~reset;
    assign divresp_rdy    = divresp_rdy_q    & ~reset;

endmodule

// File: rtl/imuldiv_muldiv_dispatch.sv
// Mul/div front end: latches one request, forwards it to the multiplier or divider, returns the 32-bit result.
// Latency: 3 cycles plus the unit's own latency; illegal fn answers 0 one cycle after accept.
// Backpressure: one op in flight; muldivreq_rdy low from accept until the response transfers.
// Ports: muldivreq_* (fn/a/b in), muldivresp_* (result out), mulreq_*/mulresp_* to the
//        multiplier, divreq_*/divresp_* to the divider (divresp = {rem, quo}).
module imuldiv_muldiv_dispatch
    import imuldiv_muldiv_dispatch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic [2:0]  muldivreq_msg_fn,
    input  logic [31:0] muldivreq_msg_a,
    input  logic [31:0] muldivreq_msg_b,
    input  logic        muldivreq_val,
    output logic        muldivreq_rdy,

    output logic [31:0] muldivresp_msg_result,
    output logic        muldivresp_val,
    input  logic        muldivresp_rdy,

    output logic [31:0] mulreq_msg_a,
    output logic [31:0] mulreq_msg_b,
    output logic        mulreq_val,
    input  logic        mulreq_rdy,
    input  logic [63:0] mulresp_msg_result,
    input  logic        mulresp_val,
    output logic        mulresp_rdy,

    output logic        divreq_msg_fn,
    output logic [31:0] divreq_msg_a,
    output logic [31:0] divreq_msg_b,
    output logic        divreq_val,
    input  logic        divreq_rdy,
    input  logic [63:0] divresp_msg_result,
    input  logic        divresp_val,
    output logic        divresp_rdy
);

    muldivreq_msg_t req_q, req_d;
    logic [31:0]    result_q, result_d;

    logic        req_en;
    logic        result_en;
    result_sel_e result_sel;

    imuldiv_muldiv_dispatch_ctrl u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .muldivreq_val  (muldivreq_val),
        .req_fn         (muldivreq_msg_fn),
        .fn_reg         (req_q.fn),
        .muldivreq_rdy  (muldivreq_rdy),
        .muldivresp_val (muldivresp_val),
        .muldivresp_rdy (muldivresp_rdy),
        .mulreq_val     (mulreq_val),
        .mulreq_rdy     (mulreq_rdy),
        .mulresp_val    (mulresp_val),
        .mulresp_rdy    (mulresp_rdy),
        .divreq_val     (divreq_val),
        .divreq_rdy     (divreq_rdy),
        .divresp_val    (divresp_val),
        .divresp_rdy    (divresp_rdy),
        .req_en         (req_en),
        .result_en      (result_en),
        .result_sel     (result_sel)
    );

    always_comb begin
        req_d = req_q;
        if (req_en) begin
            req_d.fn = muldivreq_msg_fn;
            req_d.a  = muldivreq_msg_a;
            req_d.b  = muldivreq_msg_b;
        end

        result_d = result_q;
        if (result_en) begin
            case (result_sel)
                RSEL_MUL_LO:  result_d = mulresp_msg_result[31:0];
                RSEL_DIV_QUO: result_d = divresp_msg_result[31:0];
                RSEL_DIV_REM: result_d = divresp_msg_result[63:32];
                default:      result_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q    <= '0;
            result_q <= '0;
        end else begin
            req_q    <= req_d;
            result_q <= result_d;
        end
    end

    // Operands come straight from the held request, so they stay put for as
    // long as a unit stalls its request channel.
    assign mulreq_msg_a          = req_q.a;
    assign mulreq_msg_b          = req_q.b;
    assign divreq_msg_a          = req_q.a;
    assign divreq_msg_b          = req_q.b;
    assign divreq_msg_fn         = fn_div_sign(req_q.fn);
    assign muldivresp_msg_result = result_q;

    // Only the low word of the product is architectural.
    logic unused_mulresp_hi;
    assign unused_mulresp_hi = ^mulresp_msg_result[63:32];

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
module tb_imuldiv_muldiv_dispatch;
    import imuldiv_muldiv_dispatch_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  muldivreq_msg_fn;
    logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
    logic        muldivreq_val, muldivreq_rdy;
    logic [31:0] muldivresp_msg_result;
    logic        muldivresp_val, muldivresp_rdy;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val, mulreq_rdy;
    logic [63:0] mulresp_msg_result;
    logic        mulresp_val, mulresp_rdy;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divreq_val, divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val, divresp_rdy;

    imuldiv_muldiv_dispatch dut (
        .clk(clk), .reset(reset),
        .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
        .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
        .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
        .muldivresp_rdy(muldivresp_rdy),
        .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val),
        .mulreq_rdy(mulreq_rdy), .mulresp_msg_result(mulresp_msg_result),
        .mulresp_val(mulresp_val), .mulresp_rdy(mulresp_rdy),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy), .divresp_msg_result(divresp_msg_result),
        .divresp_val(divresp_val), .divresp_rdy(divresp_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    // Divider conventions for the corner cases: x/0 -> all ones rem x; MIN/-1 -> MIN rem 0.
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] fn, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] q, r;
        case (fn)
            3'd0: return a * b;
            3'd1: begin ref_div(1'b1, a, b, q, r); return q; end
            3'd2: begin ref_div(1'b0, a, b, q, r); return q; end
            3'd3: begin ref_div(1'b1, a, b, q, r); return r; end
            3'd4: begin ref_div(1'b0, a, b, q, r); return r; end
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- environment knobs (written by stimulus only) ----------------
    logic mul_stall = 1'b0;
    logic div_stall = 1'b0;
    logic resp_stall = 1'b0;
    int   div_lat_min = 0;

    // ---------------- multiplier model ----------------
    initial begin : mul_model
        logic rx, tx, rst, busy;
        logic [31:0] ca, cb;
        int lat;
        mulreq_rdy = 1'b0; mulresp_val = 1'b0; mulresp_msg_result = '0;
        busy = 1'b0; lat = 0;
        forever begin
            @(negedge clk);
            rx = mulreq_val && mulreq_rdy; tx = mulresp_val && mulresp_rdy; rst = reset;
            ca = mulreq_msg_a; cb = mulreq_msg_b;
            @(posedge clk); #1;
            if (rst) begin
                busy = 1'b0; mulresp_val = 1'b0;
            end else begin
                if (tx) begin busy = 1'b0; mulresp_val = 1'b0; end
                if (rx) begin
                    busy = 1'b1; lat = $urandom_range(0, 3);
                    // Junk in the high word: only the low word may be selected.
                    mulresp_msg_result = {32'($urandom), ca * cb};
                end
                if (busy && !mulresp_val) begin
                    if (lat == 0) mulresp_val = 1'b1; else lat--;
                end
            end
            mulreq_rdy = !busy && !mul_stall && ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- divider model ----------------
    initial begin : div_model
        logic rx, tx, rst, busy, sg;
        logic [31:0] ca, cb, q, r;
        int lat;
        divreq_rdy = 1'b0; divresp_val = 1'b0; divresp_msg_result = '0;
        busy = 1'b0; lat = 0;
        forever begin
            @(negedge clk);
            rx = divreq_val && divreq_rdy; tx = divresp_val && divresp_rdy; rst = reset;
            ca = divreq_msg_a; cb = divreq_msg_b; sg = divreq_msg_fn;
            @(posedge clk); #1;
            if (rst) begin
                busy = 1'b0; divresp_val = 1'b0;
            end else begin
                if (tx) begin busy = 1'b0; divresp_val = 1'b0; end
                if (rx) begin
                    busy = 1'b1; lat = div_lat_min + $urandom_range(0, 3);
                    ref_div(sg, ca, cb, q, r);
                    divresp_msg_result = {r, q};
                end
                if (busy && !divresp_val) begin
                    if (lat == 0) divresp_val = 1'b1; else lat--;
                end
            end
            divreq_rdy = !busy && !div_stall && ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- response sink ----------------
    initial begin
        muldivresp_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            muldivresp_rdy = !resp_stall && ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [2:0]  fn;
        logic [31:0] a, b, exp;
        int          acc;
        logic        lat_done;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] last_result = '0, prev_result = '0;
    logic        last_div_fn = 1'b0;
    int          rdy_rise = 0, divval_rise = 0, mulval_rise = 0, div_xfer_cnt = 0;

    initial begin : monitor
        exp_t e;
        logic have_prev;
        logic p_rv, p_rr, p_dv, p_dr, p_df, p_mv, p_mr, p_qr, p_dv_any, p_mv_any;
        logic [31:0] p_res, p_da, p_db, p_ma, p_mb;
        have_prev = 1'b0; p_qr = 1'b0; p_dv_any = 1'b0; p_mv_any = 1'b0;
        {p_rv, p_rr, p_dv, p_dr, p_df, p_mv, p_mr} = '0;
        {p_res, p_da, p_db, p_ma, p_mb} = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                have_prev = 1'b0;
            end else begin
                if (have_prev && p_rv && !p_rr)
                    check("resp_hold", {muldivresp_val, muldivresp_msg_result}, {1'b1, p_res});
                if (have_prev && p_dv && !p_dr)
                    check("div_op_hold", {divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b},
                          {1'b1, p_df, p_da, p_db});
                if (have_prev && p_mv && !p_mr)
                    check("mul_op_hold", {mulreq_val, mulreq_msg_a, mulreq_msg_b}, {1'b1, p_ma, p_mb});

                if (muldivresp_val) begin
                    check("req_rdy_low_in_resp", muldivreq_rdy, 0);
                    check("resp_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        if (fn_is_illegal(exp_q[0].fn) && !exp_q[0].lat_done) begin
                            check("illegal_latency", cyc - exp_q[0].acc, 1);
                            exp_q[0].lat_done = 1'b1;
                        end
                        if (muldivresp_rdy) begin
                            e = exp_q.pop_front();
                            check("result", muldivresp_msg_result, e.exp);
                            prev_result = last_result;
                            last_result = muldivresp_msg_result;
                        end
                    end
                end

                if (mulreq_val) begin
                    check("mul_issue_is_mul", cur.fn, FN_MUL);
                    if (mulreq_rdy)
                        check("mul_fwd", {mulreq_msg_a, mulreq_msg_b}, {cur.a, cur.b});
                end
                if (divreq_val) begin
                    check("div_issue_is_div", (cur.fn != FN_MUL) && !fn_is_illegal(cur.fn), 1);
                    if (divreq_rdy) begin
                        check("div_fwd", {divreq_msg_fn, divreq_msg_a, divreq_msg_b},
                              {((cur.fn == FN_DIV) || (cur.fn == FN_REM)), cur.a, cur.b});
                        last_div_fn = divreq_msg_fn;
                        div_xfer_cnt++;
                    end
                end

                if (muldivreq_val && muldivreq_rdy) begin
                    check("no_overlap", exp_q.size(), 0);
                    e.fn = muldivreq_msg_fn; e.a = muldivreq_msg_a; e.b = muldivreq_msg_b;
                    e.exp = ref_result(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b);
                    e.acc = cyc; e.lat_done = 1'b0;
                    exp_q.push_back(e);
                    cur = e;
                end
                have_prev = 1'b1;
            end

            if (muldivreq_rdy && !p_qr) rdy_rise++;
            if (divreq_val && !p_dv_any) divval_rise++;
            if (mulreq_val && !p_mv_any) mulval_rise++;
            p_qr = muldivreq_rdy; p_dv_any = divreq_val; p_mv_any = mulreq_val;
            p_rv = muldivresp_val; p_rr = muldivresp_rdy; p_res = muldivresp_msg_result;
            p_dv = divreq_val; p_dr = divreq_rdy; p_df = divreq_msg_fn;
            p_da = divreq_msg_a; p_db = divreq_msg_b;
            p_mv = mulreq_val; p_mr = mulreq_rdy; p_ma = mulreq_msg_a; p_mb = mulreq_msg_b;
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic send_req(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        muldivreq_val = 1'b1; muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b;
        do begin
            @(negedge clk); t++;
        end while (!muldivreq_rdy && t < 300);
        check("req_accepted", muldivreq_rdy, 1);
        @(posedge clk); #1;
        muldivreq_val = 1'b0;
        muldivreq_msg_fn = 3'($urandom); muldivreq_msg_a = $urandom; muldivreq_msg_b = $urandom;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk); t++;
        end while (!(exp_q.size() == 0 && muldivreq_rdy) && t < 1000);
        check("drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stim
        int b_rdy, b_dv, b_mv, t, r;
        logic [2:0] fn;
        reset = 1'b1; muldivreq_val = 1'b0;
        muldivreq_msg_fn = '0; muldivreq_msg_a = '0; muldivreq_msg_b = '0;

        // Reset behaviour.
        @(negedge clk);
        check("reset_hs_outputs", {muldivreq_rdy, muldivresp_val, mulreq_val, mulresp_rdy,
                                   divreq_val, divresp_rdy}, 6'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_req_rdy", muldivreq_rdy, 1);
        check("post_reset_resp", {muldivresp_val, muldivresp_msg_result}, 33'd0);
        @(posedge clk); #1;

        // DIV signed -7 / 2.
        b_rdy = rdy_rise; b_dv = divval_rise; b_mv = mulval_rise;
        send_req(FN_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        check("div_m7_2", last_result, 32'hFFFF_FFFD);
        check("div_signed_fn", last_div_fn, 1);
        check("div_req_rdy_rises", rdy_rise - b_rdy, 1);
        check("div_val_rises", divval_rise - b_dv, 1);

        // REMU 0xFFFFFFFF % 10.
        b_mv = mulval_rise;
        send_req(FN_REMU, 32'hFFFF_FFFF, 32'd10);
        wait_idle();
        check("remu_result", last_result, 32'd5);
        check("remu_unsigned_fn", last_div_fn, 0);
        check("remu_mul_idle", mulval_rise - b_mv, 0);

        // MUL pair back to back.
        send_req(FN_MUL, 32'h0001_0000, 32'h0001_0000);
        send_req(FN_MUL, 32'd3, 32'hFFFF_FFFC);
        wait_idle();
        check("mul_2p32_lo", prev_result, 32'd0);
        check("mul_3_m4", last_result, 32'hFFFF_FFF4);

        // Divider request stalled for 5 cycles.
        div_stall = 1'b1;
        send_req(FN_DIV, 32'd1000, 32'hFFFF_FFFD);
        t = 0;
        while (!divreq_val && t < 50) begin @(posedge clk); #1; t++; end
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        check("div_val_held", divreq_val, 1);
        @(posedge clk); #1;
        div_stall = 1'b0;
        wait_idle();
        check("div_1000_m3", last_result, 32'hFFFF_FEB3);

        // Response channel stalled for 7 cycles.
        resp_stall = 1'b1;
        send_req(FN_MUL, 32'd7, 32'd6);
        t = 0;
        while (!muldivresp_val && t < 50) begin @(posedge clk); #1; t++; end
        repeat (7) begin @(posedge clk); #1; end
        @(negedge clk);
        check("resp_stall_state", {muldivresp_val, muldivreq_rdy, muldivresp_msg_result},
              {1'b1, 1'b0, 32'd42});
        @(posedge clk); #1;
        resp_stall = 1'b0;
        wait_idle();

        // Illegal function code.
        b_dv = divval_rise; b_mv = mulval_rise;
        send_req(3'd6, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_idle();
        check("illegal_result", last_result, 32'd0);
        check("illegal_no_unit", {divval_rise - b_dv, mulval_rise - b_mv}, 64'd0);

        // Reset while waiting on the divider.
        div_lat_min = 10;
        b_dv = div_xfer_cnt;
        send_req(FN_DIVU, 32'd5, 32'd1);
        t = 0;
        while (div_xfer_cnt == b_dv && t < 50) begin @(negedge clk); t++; end
        check("div_issued_before_reset", div_xfer_cnt - b_dv, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midop_reset_outputs", {muldivreq_rdy, muldivresp_val, divresp_rdy}, 3'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        div_lat_min = 0;
        @(negedge clk);
        check("after_midop_reset", {muldivreq_rdy, muldivresp_val, muldivresp_msg_result},
              {1'b1, 1'b0, 32'd0});
        @(posedge clk); #1;
        send_req(FN_DIVU, 32'd100, 32'd7);
        wait_idle();
        check("divu_100_7", last_result, 32'd14);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      fn = FN_MUL;
            else if (r < 9) fn = 3'(1 + (r - 2) % 4);
            else            fn = 3'(5 + $urandom_range(0, 2));
            send_req(fn, pick_op(), pick_op());
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
